kernel_bank: RTL and testbench
==============================

KERNEL_BANK -- requirements
Module: kernel_bank

Interface
REQ-001 Parameter DWIDTH_SLICE, default 5, kernel side length; N = DWIDTH_SLICE*DWIDTH_SLICE coefficients.
REQ-002 Parameter DWIDTH_KERNEL, default 4, signed two's-complement coefficient width.
REQ-003 Parameter DWIDTH_DIV, default 4, divisor right-shift amount width.
REQ-004 Parameter NUM_KERNELS, default 4, number of stored kernel slots; SELW = clog2(NUM_KERNELS), minimum 1.
REQ-005 Port clk input 1: single clock; all state changes on its rising edge.
REQ-006 Port rst_n input 1: reset, asynchronous and active-low.
REQ-007 Port kernel_select input SELW: slot to present at the next frame boundary.
REQ-008 Port frame_start input 1: one-cycle pulse marking the frame boundary.
REQ-009 Port wr_start input 1: pulse that begins a slot reload.
REQ-010 Port wr_slot input SELW: target slot, sampled with wr_start.
REQ-011 Port wr_div input DWIDTH_DIV: new divisor, sampled with wr_start.
REQ-012 Port wr_valid input 1 / wr_coeff input DWIDTH_KERNEL: coefficient stream.
REQ-013 Port wr_abort input 1: discards an in-progress reload.
REQ-014 Port wr_ready output 1: high while the load state machine accepts coefficients.
REQ-015 Port wr_done output 1: one-cycle pulse when a reload commits.
REQ-016 Port kernel output N*DWIDTH_KERNEL: active kernel; coefficient 0 (top-left) in the MSBs, row-major.
REQ-017 Port div output DWIDTH_DIV / active_slot output SELW: active divisor and the slot it came from.

Function
REQ-018 Storage: NUM_KERNELS slots, each N coefficients plus one divisor; one N-coefficient staging buffer.
REQ-019 kernel, div and active_slot are registered; they change only on a cycle with frame_start=1 and take slot[kernel_select] one cycle later.
REQ-020 The load state machine has two states, IDLE and LOAD.
REQ-021 IDLE: wr_ready=0; wr_start=1 latches wr_slot and wr_div, clears the index counter to 0, and moves to LOAD.
REQ-022 LOAD: wr_ready=1; each cycle with wr_valid=1 writes wr_coeff to staging[index] and increments index.
REQ-023 Acceptance of index N-1 copies staging plus the latched divisor into the target slot in the same edge, pulses wr_done the next cycle, and returns to IDLE.
REQ-024 Slot contents update atomically; no slot is ever partially written.
REQ-025 wr_start during LOAD is ignored.
REQ-026 wr_abort=1 in LOAD returns to IDLE next cycle without committing; wr_abort has priority over wr_valid in the same cycle; wr_abort in IDLE has no effect.
REQ-027 Commit and frame_start on the same edge: the outputs load the pre-commit slot contents; the new contents appear at the following frame_start.
REQ-028 Reloading the active slot does not alter kernel or div until the next frame_start.
REQ-029 kernel_select >= NUM_KERNELS at frame_start selects slot 0; wr_slot >= NUM_KERNELS at wr_start is ignored and the machine stays in IDLE.
REQ-030 No arithmetic is performed on coefficients; values are stored and reproduced bit-exact.

Reset
REQ-031 rst_n=0 forces IDLE, index=0, wr_ready=0, wr_done=0, and active_slot=0 immediately.
REQ-032 Reset presets with DWIDTH_SLICE=5 and DWIDTH_KERNEL=4 (rows top to bottom, hex):
  - Slot 0, combined Sobel, div 0: 00000 / 00220 / 0E020 / 0EE00 / 00000.
  - Slot 1, blur, div 5: 01110 / 12221 / 12421 / 12221 / 01110.
  - Remaining slots: identity (centre coefficient 1, others 0), div 0.
REQ-033 With any other parameter set, every slot resets to identity with div 0.
REQ-034 During reset, kernel and div equal slot 0 presets; an assertion of rst_n mid-LOAD discards the staging contents.

Verification
REQ-035 Reset release, kernel_select=1, frame_start pulse -> kernel=slot 0 Sobel until the pulse, then blur with div=5 and active_slot=1 one cycle after.
REQ-036 Reload slot 2: wr_start with wr_div=3, then 25 coefficients 1..9,A..F,0..9 with gaps in wr_valid -> wr_done pulses once after the 25th; kernel_select=2 plus frame_start -> the exact sequence with coefficient 0 in the MSBs, div=3.
REQ-037 Reload the active slot 1 while presenting it -> kernel stays blur until the next frame_start, then shows the new contents.
REQ-038 wr_abort after 10 coefficients -> no wr_done; slot unchanged; a new wr_start restarts at index 0.
REQ-039 Final coefficient and frame_start on the same cycle -> old contents presented; new contents at the next frame_start.
REQ-040 rst_n low mid-LOAD -> wr_ready=0 immediately; all slots back at presets; kernel=Sobel, div=0.

Source files
------------

// File: rtl/kernel_bank.sv
// -----------------------------------------------------------------------------
// kernel_bank
//   Bank of NUM_KERNELS convolution kernels (DWIDTH_SLICE x DWIDTH_SLICE signed
//   coefficients plus a divisor shift each). One slot is presented on the
//   registered kernel/div/active_slot outputs and swapped only at frame
//   boundaries. Any slot can be reloaded through a staging buffer while the
//   bank is in use; a reload lands in its slot in a single edge, so a slot is
//   never seen half-written.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   kernel_select   : slot to present at the next frame_start
//   frame_start     : one-cycle frame boundary pulse
//   wr_start        : begin a reload (samples wr_slot, wr_div)
//   wr_slot, wr_div : reload target slot and divisor
//   wr_valid        : wr_coeff carries the next coefficient (row-major)
//   wr_coeff        : coefficient value
//   wr_abort        : drop the reload in progress
//   wr_ready        : high while coefficients are accepted
//   wr_done         : one-cycle pulse after a reload commits
//   kernel          : active kernel, coefficient 0 (top-left) in the MSBs
//   div             : active divisor
//   active_slot     : slot the active kernel came from
// -----------------------------------------------------------------------------
module kernel_bank #(
  parameter int DWIDTH_SLICE  = 5,
  parameter int DWIDTH_KERNEL = 4,
  parameter int DWIDTH_DIV    = 4,
  parameter int NUM_KERNELS   = 4,
  localparam int N    = DWIDTH_SLICE * DWIDTH_SLICE,
  localparam int KW   = N * DWIDTH_KERNEL,
  localparam int SELW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [SELW-1:0]                 kernel_select,
  input  logic                            frame_start,
  input  logic                            wr_start,
  input  logic [SELW-1:0]                 wr_slot,
  input  logic [DWIDTH_DIV-1:0]           wr_div,
  input  logic                            wr_valid,
  input  logic signed [DWIDTH_KERNEL-1:0] wr_coeff,
  input  logic                            wr_abort,
  output logic                            wr_ready,
  output logic                            wr_done,
  output logic [KW-1:0]                   kernel,
  output logic [DWIDTH_DIV-1:0]           div,
  output logic [SELW-1:0]                 active_slot
);

  localparam int IDXW   = (N > 1) ? $clog2(N) : 1;
  localparam int CENTRE = (DWIDTH_SLICE / 2) * DWIDTH_SLICE + (DWIDTH_SLICE / 2);
  // The named presets only make sense for the 5x5, 4-bit geometry.
  localparam bit PRESETS = (DWIDTH_SLICE == 5) && (DWIDTH_KERNEL == 4);

  localparam logic [99:0] SOBEL_PRESET = 100'h00000_00220_0E020_0EE00_00000;
  localparam logic [99:0] BLUR_PRESET  = 100'h01110_12221_12421_12221_01110;

  typedef enum logic {IDLE, LOAD} state_t;

  function automatic logic [KW-1:0] preset_kernel(input int s);
    logic [KW-1:0] r;
    int            t;
    r = '0;
    if (PRESETS && (s < 2)) begin
      for (int k = 0; k < N; k++) begin
        t = (k < 25) ? (24 - k) * 4 : 0;
        r[(N-1-k)*DWIDTH_KERNEL +: DWIDTH_KERNEL] = (s == 0) ?
          DWIDTH_KERNEL'(SOBEL_PRESET[t +: 4]) : DWIDTH_KERNEL'(BLUR_PRESET[t +: 4]);
      end
    end else begin
      r[(N-1-CENTRE)*DWIDTH_KERNEL +: DWIDTH_KERNEL] = DWIDTH_KERNEL'(1);
    end
    return r;
  endfunction

  function automatic logic [DWIDTH_DIV-1:0] preset_div(input int s);
    return (PRESETS && (s == 1)) ? DWIDTH_DIV'(5) : '0;
  endfunction

  // Slot numbers beyond the populated range are treated as invalid.
  function automatic logic slot_ok(input logic [SELW-1:0] s);
    return int'({1'b0, s}) < NUM_KERNELS;
  endfunction

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [SELW-1:0]         tgt_q, tgt_d;
  logic [DWIDTH_DIV-1:0]   ldiv_q, ldiv_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    wr_done_q, wr_done_d;
  logic [KW-1:0]           stage_q, stage_d;
  logic [KW-1:0]           slot_k_q [NUM_KERNELS];
  logic [KW-1:0]           slot_k_d [NUM_KERNELS];
  logic [DWIDTH_DIV-1:0]   slot_div_q [NUM_KERNELS];
  logic [DWIDTH_DIV-1:0]   slot_div_d [NUM_KERNELS];
  logic [KW-1:0]           kernel_q, kernel_d;
  logic [DWIDTH_DIV-1:0]   div_q, div_d;
  logic [SELW-1:0]         act_q, act_d;
  logic [SELW-1:0]         sel_eff;
  logic                    commit;

  assign sel_eff = slot_ok(kernel_select) ? kernel_select : '0;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tgt_d      = tgt_q;
    ldiv_d     = ldiv_q;
    stage_d    = stage_q;
    wr_done_d  = 1'b0;
    commit     = 1'b0;
    slot_k_d   = slot_k_q;
    slot_div_d = slot_div_q;
    kernel_d   = kernel_q;
    div_d      = div_q;
    act_d      = act_q;

    case (state_q)
      IDLE: begin
        if (wr_start && slot_ok(wr_slot)) begin
          state_d = LOAD;
          tgt_d   = wr_slot;
          ldiv_d  = wr_div;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (wr_abort) begin
          state_d = IDLE;
        end else if (wr_valid) begin
          stage_d[(N-1-int'(idx_q))*DWIDTH_KERNEL +: DWIDTH_KERNEL] = wr_coeff;
          if (idx_q == IDXW'(N-1)) begin
            commit    = 1'b1;
            wr_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase

    wr_ready_d = (state_d == LOAD);

    // stage_d already holds the final coefficient, so the whole kernel moves
    // into its slot on the accepting edge.
    if (commit) begin
      slot_k_d[tgt_q]   = stage_d;
      slot_div_d[tgt_q] = ldiv_q;
    end

    // Outputs read the registered slots, so a commit on the same edge is not
    // visible until the following frame boundary.
    if (frame_start) begin
      kernel_d = slot_k_q[sel_eff];
      div_d    = slot_div_q[sel_eff];
      act_d    = sel_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tgt_q      <= '0;
      ldiv_q     <= '0;
      wr_ready_q <= 1'b0;
      wr_done_q  <= 1'b0;
      for (int s = 0; s < NUM_KERNELS; s++) begin
        slot_k_q[s]   <= preset_kernel(s);
        slot_div_q[s] <= preset_div(s);
      end
      kernel_q   <= preset_kernel(0);
      div_q      <= preset_div(0);
      act_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tgt_q      <= tgt_d;
      ldiv_q     <= ldiv_d;
      wr_ready_q <= wr_ready_d;
      wr_done_q  <= wr_done_d;
      slot_k_q   <= slot_k_d;
      slot_div_q <= slot_div_d;
      kernel_q   <= kernel_d;
      div_q      <= div_d;
      act_q      <= act_d;
    end
  end

  // Staging contents are only meaningful after a reload has started, which
  // always rewrites every entry before committing.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign wr_ready    = wr_ready_q;
  assign wr_done     = wr_done_q;
  assign kernel      = kernel_q;
  assign div         = div_q;
  assign active_slot = act_q;

endmodule

// File: tb/tb_kernel_bank.sv
// -----------------------------------------------------------------------------
// tb_kernel_bank
//   Self-checking bench for kernel_bank with default parameters. A behavioural
//   model (slot arrays, coefficient queue) predicts every output each cycle;
//   directed sequences cover the frame/commit interactions and random traffic
//   follows.
// -----------------------------------------------------------------------------
module tb_kernel_bank;

  localparam int N  = 25;
  localparam int KW = 100;
  localparam int NK = 4;

  localparam logic [KW-1:0] SOBEL_HEX = 100'h00000_00220_0E020_0EE00_00000;
  localparam logic [KW-1:0] BLUR_HEX  = 100'h01110_12221_12421_12221_01110;
  localparam logic [KW-1:0] IDENT_HEX = 100'h00000_00000_00100_00000_00000;
  localparam logic [KW-1:0] SEQ_HEX   = 100'h12345_6789A_BCDEF_01234_56789;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    kernel_select = '0;
  logic          frame_start = 1'b0;
  logic          wr_start = 1'b0;
  logic [1:0]    wr_slot = '0;
  logic [3:0]    wr_div = '0;
  logic          wr_valid = 1'b0;
  logic [3:0]    wr_coeff = '0;
  logic          wr_abort = 1'b0;
  logic          wr_ready;
  logic          wr_done;
  logic [KW-1:0] kernel;
  logic [3:0]    div;
  logic [1:0]    active_slot;

  kernel_bank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .kernel_select (kernel_select),
    .frame_start   (frame_start),
    .wr_start      (wr_start),
    .wr_slot       (wr_slot),
    .wr_div        (wr_div),
    .wr_valid      (wr_valid),
    .wr_coeff      (wr_coeff),
    .wr_abort      (wr_abort),
    .wr_ready      (wr_ready),
    .wr_done       (wr_done),
    .kernel        (kernel),
    .div           (div),
    .active_slot   (active_slot)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presets written out row by row, top-left first.
  int sobel_c [25] = '{0,0,0,0,0,  0,0,2,2,0,  0,14,0,2,0,  0,14,14,0,0,  0,0,0,0,0};
  int blur_c  [25] = '{0,1,1,1,0,  1,2,2,2,1,  1,2,4,2,1,  1,2,2,2,1,  0,1,1,1,0};

  int            m_k   [NK][N];
  int            m_div [NK];
  bit            m_loading;
  int            m_tgt;
  int            m_ldiv;
  int            m_buf [$];
  logic [KW-1:0] exp_kernel;
  int            exp_div;
  int            exp_act;
  bit            exp_done;

  function automatic logic [KW-1:0] pack(input int s);
    logic [KW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r = {r[KW-5:0], 4'(m_k[s][k])};
    return r;
  endfunction

  task automatic mdl_reset();
    for (int s = 0; s < NK; s++) begin
      for (int k = 0; k < N; k++)
        m_k[s][k] = (s == 0) ? sobel_c[k] : (s == 1) ? blur_c[k] : ((k == 12) ? 1 : 0);
      m_div[s] = (s == 1) ? 5 : 0;
    end
    m_loading  = 1'b0;
    m_buf.delete();
    exp_kernel = pack(0);
    exp_div    = 0;
    exp_act    = 0;
    exp_done   = 1'b0;
  endtask

  task automatic mdl_edge();
    int s;
    if (!rst_n) begin
      mdl_reset();
      return;
    end
    exp_done = 1'b0;
    if (frame_start) begin
      s = int'(kernel_select);
      if (s >= NK) s = 0;
      exp_kernel = pack(s);
      exp_div    = m_div[s];
      exp_act    = s;
    end
    if (!m_loading) begin
      if (wr_start && int'(wr_slot) < NK) begin
        m_loading = 1'b1;
        m_tgt     = int'(wr_slot);
        m_ldiv    = int'(wr_div);
        m_buf.delete();
      end
    end else if (wr_abort) begin
      m_loading = 1'b0;
    end else if (wr_valid) begin
      m_buf.push_back(int'(wr_coeff));
      if (m_buf.size() == N) begin
        for (int k = 0; k < N; k++) m_k[m_tgt][k] = m_buf[k];
        m_div[m_tgt] = m_ldiv;
        exp_done     = 1'b1;
        m_loading    = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("kernel", kernel, exp_kernel);
    chk("div", div, exp_div);
    chk("active_slot", active_slot, exp_act);
    chk("wr_ready", wr_ready, m_loading);
    chk("wr_done", wr_done, exp_done);
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_edge();
    #1;
    check_outputs();
  endtask

  task automatic start_load(input int slot, input int dv);
    wr_start = 1'b1;
    wr_slot  = 2'(slot);
    wr_div   = 4'(dv);
    tick();
    wr_start = 1'b0;
  endtask

  task automatic push(input int c, input int maxgap);
    int g;
    g = int'($urandom_range(0, maxgap));
    repeat (g) tick();
    wr_valid = 1'b1;
    wr_coeff = 4'(c);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic present(input int slot);
    kernel_select = 2'(slot);
    frame_start   = 1'b1;
    tick();
    frame_start   = 1'b0;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    mdl_reset();
    check_outputs();
    chk("rst_ready_now", wr_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    mdl_reset();
    check_outputs();
    chk("rst_kernel", kernel, SOBEL_HEX);
    chk("rst_div", div, 0);
    rst_n = 1'b1;
    tick();

    // Frame-boundary swap to the blur preset
    kernel_select = 2'd1;
    tick();
    chk("pre_frame_sobel", kernel, SOBEL_HEX);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("blur_kernel", kernel, BLUR_HEX);
    chk("blur_div", div, 5);
    chk("blur_slot", active_slot, 1);

    // Reload slot 2 with a known sequence and gaps in wr_valid
    start_load(2, 3);
    for (int i = 0; i < N; i++) push((i < 15) ? i + 1 : i - 15, 2);
    chk("seq_done", wr_done, 1);
    tick();
    chk("seq_done_once", wr_done, 0);
    present(2);
    chk("seq_kernel", kernel, SEQ_HEX);
    chk("seq_div", div, 3);

    // Reload the slot being presented
    present(1);
    start_load(1, 9);
    for (int i = 0; i < N; i++) push(int'($urandom_range(0, 15)), 1);
    tick();
    chk("active_hold_kernel", kernel, BLUR_HEX);
    chk("active_hold_div", div, 5);
    present(1);
    chk("active_new_div", div, 9);

    // Abort after 10 coefficients, then a clean reload with a stray wr_start
    start_load(3, 7);
    for (int i = 0; i < 10; i++) push(int'($urandom_range(0, 15)), 1);
    wr_abort = 1'b1;
    wr_valid = 1'b1;
    tick();
    wr_abort = 1'b0;
    wr_valid = 1'b0;
    repeat (3) tick();
    chk("abort_ready", wr_ready, 0);
    present(3);
    chk("abort_kernel", kernel, IDENT_HEX);
    start_load(3, 6);
    for (int i = 0; i < N; i++) begin
      if (i == 5) begin
        wr_start = 1'b1;
        wr_slot  = 2'd1;
        wr_div   = 4'd2;
      end
      push(int'($urandom_range(0, 15)), 1);
      wr_start = 1'b0;
    end
    present(3);
    chk("restart_div", div, 6);

    // Final coefficient coincides with frame_start
    present(2);
    start_load(0, 4);
    for (int i = 0; i < N - 1; i++) push(int'($urandom_range(0, 15)), 0);
    wr_valid      = 1'b1;
    wr_coeff      = 4'($urandom_range(0, 15));
    kernel_select = 2'd0;
    frame_start   = 1'b1;
    tick();
    wr_valid      = 1'b0;
    frame_start   = 1'b0;
    chk("same_edge_old", kernel, SOBEL_HEX);
    chk("same_edge_done", wr_done, 1);
    present(0);
    chk("same_edge_new_div", div, 4);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      frame_start   = ($urandom_range(0, 7) == 0);
      kernel_select = 2'($urandom_range(0, 3));
      wr_start      = ($urandom_range(0, 15) == 0);
      wr_slot       = 2'($urandom_range(0, 3));
      wr_div        = 4'($urandom_range(0, 15));
      wr_valid      = ($urandom_range(0, 1) == 1);
      wr_coeff      = 4'($urandom_range(0, 15));
      wr_abort      = ($urandom_range(0, 79) == 0);
      tick();
    end
    frame_start = 1'b0;
    wr_start    = 1'b0;
    wr_valid    = 1'b0;
    wr_abort    = 1'b0;

    // Reset in the middle of a reload
    wr_abort = 1'b1;
    tick();
    wr_abort = 1'b0;
    start_load(2, 1);
    for (int i = 0; i < 7; i++) push(int'($urandom_range(0, 15)), 0);
    mid_reset();
    tick();
    chk("post_rst_kernel", kernel, SOBEL_HEX);
    chk("post_rst_div", div, 0);
    present(1);
    chk("post_rst_blur", kernel, BLUR_HEX);
    present(2);
    chk("post_rst_ident", kernel, IDENT_HEX);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
